// File: rtl/ysyx_22051468_muldiv_ctrl.sv
`default_nettype none
// ysyx_22051468_muldiv_ctrl: multi-cycle RV64M sequencer (radix-2 shift-add multiply,
// restoring divide) that holds the pipeline while busy and returns a one-cycle write-back.
module ysyx_22051468_muldiv_ctrl #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       funct3_i,
    input  logic             is_w_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic [4:0]       rd_addr_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             w_en_o,
    output logic [4:0]       w_addr_o,
    output logic [WIDTH-1:0] w_data_o
);
    localparam int HALF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [2:0]         f3;
    logic               is_w;
    logic               sign_x;
    logic               sign_a;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   result;
    logic [4:0]         waddr;

    function automatic logic [WIDTH-1:0] sext32(input logic [HALF-1:0] v);
        return {{(WIDTH-HALF){v[HALF-1]}}, v};
    endfunction

    // Operand conditioning for the issuing instruction
    logic             sgn1, sgn2, neg1, neg2, is_div, div0, ovf;
    logic [WIDTH-1:0] ext1, ext2, mag1, mag2, dvd, min_val, fast_res;
    logic [CNT_W-1:0] n_iter;

    assign sgn1    = ~(funct3_i == 3'd3 || funct3_i == 3'd5 || funct3_i == 3'd7);
    assign sgn2    = sgn1 && (funct3_i != 3'd2);
    assign ext1    = is_w_i ? (sgn1 ? sext32(op1_i[HALF-1:0])
                                    : {{(WIDTH-HALF){1'b0}}, op1_i[HALF-1:0]}) : op1_i;
    assign ext2    = is_w_i ? (sgn2 ? sext32(op2_i[HALF-1:0])
                                    : {{(WIDTH-HALF){1'b0}}, op2_i[HALF-1:0]}) : op2_i;
    assign neg1    = sgn1 & ext1[WIDTH-1];
    assign neg2    = sgn2 & ext2[WIDTH-1];
    assign mag1    = neg1 ? -ext1 : ext1;
    assign mag2    = neg2 ? -ext2 : ext2;
    // W dividends are pre-aligned to the top so 32 shift steps consume them fully
    assign dvd     = is_w_i ? (mag1 << (WIDTH - HALF)) : mag1;
    assign min_val = is_w_i ? sext32(32'h8000_0000) : {1'b1, {(WIDTH-1){1'b0}}};
    assign is_div  = funct3_i[2];
    assign div0    = is_div & (ext2 == '0);
    assign ovf     = is_div & ~funct3_i[0] & (ext1 == min_val) & (&ext2);
    assign n_iter  = is_w_i ? CNT_W'(HALF) : CNT_W'(WIDTH);

    always_comb begin
        fast_res = '0;
        if (div0) begin
            if (funct3_i[1]) fast_res = is_w_i ? sext32(op1_i[HALF-1:0]) : op1_i;
            else             fast_res = '1;
        end else if (ovf) begin
            fast_res = funct3_i[1] ? '0 : ext1;
        end
    end

    // Restoring-divide step and final sign/width fixup
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mul_res, quo, rem, raw, fix_res;

    assign trial   = {acc[WIDTH-1:0], opb[WIDTH-1]};
    assign ge      = trial >= {1'b0, opa[WIDTH-1:0]};
    assign diff    = trial[WIDTH-1:0] - opa[WIDTH-1:0];
    assign prod    = sign_x ? -acc : acc;
    assign mul_res = (f3 == 3'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    assign quo     = sign_x ? -opb : opb;
    assign rem     = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign raw     = f3[2] ? (f3[1] ? rem : quo) : mul_res;
    assign fix_res = is_w ? sext32(raw[HALF-1:0]) : raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        w_en_o    = 1'b0;
        case (state)
            IDLE: begin
                stall_o = start_i;
                if (start_i) state_nxt = (div0 || ovf) ? DONE : CALC;
            end
            CALC: begin
                stall_o = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = FIXUP;
            end
            FIXUP: begin
                stall_o   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                w_en_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i) begin
            state_nxt = IDLE;
            w_en_o    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            f3     <= '0;
            is_w   <= 1'b0;
            sign_x <= 1'b0;
            sign_a <= 1'b0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            waddr  <= '0;
        end else begin
            case (state)
                IDLE: if (start_i && !flush_i) begin
                    f3     <= funct3_i;
                    is_w   <= is_w_i;
                    waddr  <= rd_addr_i;
                    sign_x <= neg1 ^ neg2;
                    sign_a <= neg1;
                    cnt    <= n_iter;
                    acc    <= '0;
                    if (is_div) begin
                        opa <= {{WIDTH{1'b0}}, mag2};
                        opb <= dvd;
                    end else begin
                        opa <= {{WIDTH{1'b0}}, mag1};
                        opb <= mag2;
                    end
                    if (div0 || ovf) result <= fast_res;
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (f3[2]) begin
                        acc <= {{WIDTH{1'b0}}, ge ? diff : trial[WIDTH-1:0]};
                        opb <= {opb[WIDTH-2:0], ge};
                    end else begin
                        if (opb[0]) acc <= acc + opa;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
                end
                FIXUP: if (!flush_i) result <= fix_res;
                default: ;
            endcase
        end
    end

    assign busy_o   = (state != IDLE);
    assign w_addr_o = waddr;
    assign w_data_o = result;

endmodule
`default_nettype wire
